// File: rtl/trojan_trigger_seq.sv
// Masked-pattern trigger: counts matching state samples (consecutive or cumulative),
// then drives a registered Tj_Trig pulse of PULSE_LEN cycles and re-arms or locks out.
module trojan_trigger_seq #(
    parameter int               WIDTH       = 128,
    parameter logic [WIDTH-1:0] PATTERN     = '1,
    parameter logic [WIDTH-1:0] MASK        = '1,
    parameter int               MATCH_COUNT = 1,
    parameter bit               CONSECUTIVE = 1'b0,
    parameter int               PULSE_LEN   = 2,
    parameter bit               REARM       = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] state,
    input  logic             state_valid,
    output logic             Tj_Trig,
    output logic             armed,
    output logic [7:0]       trig_count
);

    generate
        if (WIDTH < 1 || MATCH_COUNT < 1 || PULSE_LEN < 1) begin : g_bad_param
            $error("trojan_trigger_seq: WIDTH, MATCH_COUNT and PULSE_LEN must all be >= 1");
        end
    endgenerate

    localparam int CW = $clog2(MATCH_COUNT + 1);
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [CW-1:0] MC_LAST = CW'(MATCH_COUNT - 1);
    localparam logic [PW-1:0] PL_LAST = PW'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        ST_ARMED,
        ST_FIRE,
        ST_DONE
    } fsm_e;

    fsm_e          fsm_q;
    logic [CW-1:0] mcnt_q;
    logic [PW-1:0] pcnt_q;
    logic          match_q, miss_q;
    logic          match_d, miss_d;
    logic          tj_trig_q, armed_q;
    logic [7:0]    trig_count_q;

    always_comb begin
        match_d = 1'b0;
        miss_d  = 1'b0;
        if (state_valid) begin
            match_d = ((state & MASK) == (PATTERN & MASK));
            miss_d  = !match_d;
        end
    end

    // Compare stage keeps running in every FSM state; only ARMED consumes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            match_q <= match_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q        <= ST_ARMED;
            mcnt_q       <= '0;
            pcnt_q       <= '0;
            tj_trig_q    <= 1'b0;
            armed_q      <= 1'b1;
            trig_count_q <= '0;
        end else begin
            case (fsm_q)
                ST_ARMED: begin
                    if (match_q) begin
                        if (mcnt_q == MC_LAST) begin
                            fsm_q     <= ST_FIRE;
                            tj_trig_q <= 1'b1;
                            pcnt_q    <= PL_LAST;
                            mcnt_q    <= '0;
                            armed_q   <= 1'b0;
                            if (trig_count_q != 8'hFF) begin
                                trig_count_q <= trig_count_q + 8'd1;
                            end
                        end else begin
                            mcnt_q <= mcnt_q + CW'(1);
                        end
                    end else if (miss_q && CONSECUTIVE) begin
                        mcnt_q <= '0;
                    end
                end
                ST_FIRE: begin
                    if (pcnt_q != '0) begin
                        pcnt_q <= pcnt_q - PW'(1);
                    end else begin
                        tj_trig_q <= 1'b0;
                        if (REARM) begin
                            fsm_q   <= ST_ARMED;
                            armed_q <= 1'b1;
                        end else begin
                            fsm_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    tj_trig_q <= 1'b0;
                    armed_q   <= 1'b0;
                end
                default: begin
                    fsm_q     <= ST_ARMED;
                    tj_trig_q <= 1'b0;
                    armed_q   <= 1'b1;
                end
            endcase
        end
    end

    assign Tj_Trig    = tj_trig_q;
    assign armed      = armed_q;
    assign trig_count = trig_count_q;

endmodule

// File: doc/trojan_trigger_seq.md
Name: trojan_trigger_seq

Overview:
Parametrised successor trigger for the AES Trojan set. It watches a WIDTH-bit state bus for a masked pattern and counts matching samples, either consecutive or cumulative. After MATCH_COUNT matches it asserts Tj_Trig for PULSE_LEN cycles. It then re-arms or locks out until reset, and exposes armed status and a fire-event count for payload blocks and debug.

Parameters:
WIDTH, 128, state bus width in bits (>=1)
PATTERN, {WIDTH{1'b1}}, target value compared against state
MASK, {WIDTH{1'b1}}, 1 = bit participates in compare; 0 = don't-care
MATCH_COUNT, 1, matches required to fire (>=1)
CONSECUTIVE, 0, 1 = any valid non-match clears the match counter; 0 = matches accumulate
PULSE_LEN, 2, Tj_Trig high time in clk cycles (>=1)
REARM, 0, 1 = return to ARMED after pulse; 0 = stay in DONE until reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low
state  input  WIDTH  monitored data (AES round state)
state_valid  input  1  qualifies state; samples with state_valid=0 are ignored
Tj_Trig  output  1  registered trigger pulse to payload
armed  output  1  high while FSM in ARMED
trig_count  output  8  number of completed fire events, saturates at 255

Behaviour:
- Reset: rst=0 at a rising clk edge clears everything: FSM=ARMED, match counter=0, match_q=0, pulse counter=0, Tj_Trig=0, armed=1, trig_count=0. Reset overrides all other activity, including mid-pulse. Tj_Trig drops at that edge.
- Compare stage, registered: match_q <= state_valid & ((state & MASK) == (PATTERN & MASK)). miss_q <= state_valid & ~match. MASK=0 makes every valid sample match.
- Match counter: width $clog2(MATCH_COUNT+1). It updates only in ARMED.
  - match_q=1: counter increments.
  - miss_q=1 with CONSECUTIVE=1: counter clears to 0.
  - miss_q=1 with CONSECUTIVE=0: counter holds.
  - Idle cycles (state_valid=0): never affect the count.
- FSM states: ARMED, FIRE, DONE.
- ARMED -> FIRE on the edge where match_q=1 and counter==MATCH_COUNT-1. At that edge: Tj_Trig<=1, pulse counter<=PULSE_LEN-1, match counter<=0, armed<=0, trig_count increments (saturating).
- FIRE:
  - Tj_Trig stays high while pulse counter>0; the counter decrements each cycle.
  - On the edge where pulse counter==0: Tj_Trig<=0, and the next state is ARMED (REARM=1, armed<=1) or DONE (REARM=0).
  - Net result: Tj_Trig is high for exactly PULSE_LEN cycles.
- DONE: Tj_Trig=0, armed=0. Inputs are ignored until reset.
- Latency: the final matching sample is presented before edge E0 and captured into match_q at E0. Tj_Trig is high after E1 (2nd edge) and low after E1+PULSE_LEN.
- Matches arriving during FIRE or DONE are not counted. The counter restarts from 0 on re-arm. The match_q pipeline register keeps running, so a match sampled on the last FIRE cycle is seen in ARMED on the next edge and is counted.
- MATCH_COUNT=1: every matching valid sample fires when armed. With REARM=1, a continuously matching input gives PULSE_LEN high cycles, then 1 low cycle (ARMED), then re-fire.
- Tj_Trig is glitch-free, driven directly from a flop. No combinational path from state to any output.
- Elaboration error if MATCH_COUNT<1, PULSE_LEN<1 or WIDTH<1.

Test Plan:
1. Defaults (WIDTH=128, all-F pattern, MATCH_COUNT=1, PULSE_LEN=2, REARM=0); drive state=128'hFFFF...FF, valid=1 for one cycle at E0 -> Tj_Trig=1 after E1 and E2, 0 after E3; trig_count=1; FSM in DONE; a further all-F sample gives no pulse.
2. Defaults; state=128'hFFFF...FE, valid=1 for 10 cycles; then state all-F with valid=0 for 5 cycles -> Tj_Trig never rises; armed=1; trig_count=0.
3. MATCH_COUNT=3, CONSECUTIVE=1. Sequence match, match, miss, match, match, match -> single pulse starting 2 edges after the 6th sample. CONSECUTIVE=0 with the same sequence -> pulse 2 edges after the 4th sample.
4. MASK=128'h0000...00FF, PATTERN=128'h...A5, REARM=1, PULSE_LEN=3, MATCH_COUNT=1, state[7:0]=8'hA5 held 20 cycles with random upper bits -> repeating pattern of 3 high, 1 low; trig_count=5 after 20 cycles.
5. Reset mid-pulse: fire with PULSE_LEN=4, drive rst=0 at the 2nd pulse cycle -> Tj_Trig=0 at that edge; armed=1, trig_count=0; the next match fires normally.
6. REARM=1, MATCH_COUNT=1, PULSE_LEN=1, continuous match for 600 cycles -> trig_count saturates at 255 and holds; Tj_Trig keeps toggling 1,0.
